// File: rtl/montre_de1_sys_info_pkg.sv
// Shared constants and types for the system-info slave: register offsets,
// CTRL bit positions, data width, the decoded bus request and a byte-lane
// merge helper.
package montre_de1_sys_info_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int BE_W   = DATA_W / 8;

  // Word offsets of the register map
  typedef enum logic [ADDR_W-1:0] {
    REG_ID        = 3'd0,
    REG_TIMESTAMP = 3'd1,
    REG_UPTIME_S  = 3'd2,
    REG_UPTIME_T  = 3'd3,
    REG_SCRATCH   = 3'd4,
    REG_CTRL      = 3'd5,
    REG_CLK_HZ    = 3'd6,
    REG_RSVD      = 3'd7
  } reg_addr_e;

  // CTRL bit indices
  localparam int CTRL_FREEZE   = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLEAR    = 2;
  localparam int CTRL_IRQ_PEND = 3;

  // One decoded bus cycle as seen by the register file
  typedef struct packed {
    logic              rd;
    logic              wr;
    reg_addr_e         addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } bus_req_t;

  // Replace only the byte lanes whose enable bit is set
  function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_v,
                                                 input logic [DATA_W-1:0] new_v,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/montre_de1_sys_info_timebase.sv
// Sub-second tick counter plus free-running seconds counter.
// tick runs 0..CLK_HZ-1; the wrap advances seconds and raises sec_pulse
// for that same cycle so the interrupt logic can set on the same edge.
module montre_de1_sys_info_timebase
  import montre_de1_sys_info_pkg::*;
#(
  parameter logic [31:0] CLK_HZ = 32'd50_000_000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              freeze,
  input  logic              clear,
  output logic [DATA_W-1:0] tick,
  output logic [DATA_W-1:0] seconds,
  output logic              sec_pulse
);

  localparam logic [DATA_W-1:0] TICK_MAX = CLK_HZ - 32'd1;

  logic at_max;

  // Rollover is suppressed by freeze, and clear beats it outright
  always_comb begin
    at_max    = (tick == TICK_MAX);
    sec_pulse = at_max && !freeze && !clear;
  end

  // Counter state: clear zeroes both counters on the next edge
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tick    <= '0;
      seconds <= '0;
    end else if (clear) begin
      tick    <= '0;
      seconds <= '0;
    end else if (!freeze) begin
      if (at_max) begin
        tick    <= '0;
        seconds <= seconds + 32'd1;
      end else begin
        tick    <= tick + 32'd1;
      end
    end
  end

endmodule

// File: rtl/montre_de1_sys_info.sv
// Memory-mapped system information slave: identity words, uptime with a
// coherent seconds/tick snapshot, scratch register and a seconds interrupt.
// Reads return data exactly one cycle after acceptance.
module montre_de1_sys_info
  import montre_de1_sys_info_pkg::*;
#(
  parameter logic [31:0] SYS_ID      = 32'h6460_D4E9,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter logic [31:0] CLK_HZ      = 32'd50_000_000,
  parameter logic        IRQ_DEFAULT = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              irq
);

  bus_req_t          req;
  logic [DATA_W-1:0] tick;
  logic [DATA_W-1:0] seconds;
  logic              sec_pulse;
  logic [DATA_W-1:0] uptime_t;
  logic [DATA_W-1:0] scratch;
  logic              freeze;
  logic              irq_en;
  logic              irq_pending;
  logic              wr_ctrl;
  logic              clear;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] ctrl_rd;

  // Bus decode: a read always wins, so a simultaneous write is dropped
  always_comb begin
    req.rd    = chipselect && read;
    req.wr    = chipselect && write && !read;
    req.addr  = reg_addr_e'(address);
    req.wdata = writedata;
    req.be    = byteenable;
  end

  // CTRL lives entirely in byte lane 0; clear is a write-only pulse
  always_comb begin
    wr_ctrl = req.wr && (req.addr == REG_CTRL) && req.be[0];
    clear   = wr_ctrl && req.wdata[CTRL_CLEAR];
  end

  montre_de1_sys_info_timebase #(
    .CLK_HZ (CLK_HZ)
  ) u_timebase (
    .clock     (clock),
    .reset_n   (reset_n),
    .freeze    (freeze),
    .clear     (clear),
    .tick      (tick),
    .seconds   (seconds),
    .sec_pulse (sec_pulse)
  );

  // CTRL read image: clear always reads back as 0
  always_comb begin
    ctrl_rd                = '0;
    ctrl_rd[CTRL_FREEZE]   = freeze;
    ctrl_rd[CTRL_IRQ_EN]   = irq_en;
    ctrl_rd[CTRL_IRQ_PEND] = irq_pending;
  end

  // Read data selection for the current address
  always_comb begin
    rd_mux = '0;
    unique case (req.addr)
      REG_ID:        rd_mux = SYS_ID;
      REG_TIMESTAMP: rd_mux = TIMESTAMP;
      REG_UPTIME_S:  rd_mux = seconds;
      REG_UPTIME_T:  rd_mux = uptime_t;
      REG_SCRATCH:   rd_mux = scratch;
      REG_CTRL:      rd_mux = ctrl_rd;
      REG_CLK_HZ:    rd_mux = CLK_HZ;
      REG_RSVD:      rd_mux = '0;
      default:       rd_mux = '0;
    endcase
  end

  // Read response register: data is zero whenever valid is low
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= req.rd;
      readdata      <= req.rd ? rd_mux : '0;
    end
  end

  // Tick snapshot taken in the same cycle UPTIME_S is read
  always_ff @(posedge clock) begin
    if (!reset_n)
      uptime_t <= '0;
    else if (req.rd && req.addr == REG_UPTIME_S)
      uptime_t <= tick;
  end

  // Scratch register with per-byte write enables
  always_ff @(posedge clock) begin
    if (!reset_n)
      scratch <= '0;
    else if (req.wr && req.addr == REG_SCRATCH)
      scratch <= merge_be(scratch, req.wdata, req.be);
  end

  // CTRL RW bits
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      freeze <= 1'b0;
      irq_en <= IRQ_DEFAULT;
    end else if (wr_ctrl) begin
      freeze <= req.wdata[CTRL_FREEZE];
      irq_en <= req.wdata[CTRL_IRQ_EN];
    end
  end

  // Pending flag: a new seconds event beats a same-cycle W1C
  always_ff @(posedge clock) begin
    if (!reset_n)
      irq_pending <= 1'b0;
    else if (sec_pulse)
      irq_pending <= 1'b1;
    else if (wr_ctrl && req.wdata[CTRL_IRQ_PEND])
      irq_pending <= 1'b0;
  end

  assign irq = irq_pending && irq_en;

endmodule
